// File: rtl/dram_arb_pkg.sv
// Shared types and default payload widths for the DRAM request arbiters.
// The default widths match the FIFO's 16-bit data / 24-bit address split.
package dram_arb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dram_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid, searching upward from last+1 with wrap.
// Purely combinational so the read-request arbiter can reuse it.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] next,
  output logic          any_valid
);

  logic [N-1:0]  rot;
  logic [IW-1:0] first;

  // Rotate so bit 0 is the requester just after last
  always_comb begin
    rot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rot[i] = valid[IW'((32'(last) + 32'd1 + i) % N)];
    end
  end

  // Priority-encode the rotated vector, then undo the rotation
  always_comb begin
    first     = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_valid && rot[i]) begin
        any_valid = 1'b1;
        first     = IW'(i);
      end
    end
    next = IW'((32'(last) + 32'd1 + 32'(first)) % N);
  end

endmodule

// File: rtl/dram_wr_arbiter.sv
// Round-robin write arbiter feeding the shared address+data FIFO, with bounded
// bursts, prog_full back-pressure and a single registered output stage.
module dram_wr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                        sender_clk,
  input  logic                        sender_rst_n,
  input  logic [NUM_REQ-1:0]          req_tvalid,
  output logic [NUM_REQ-1:0]          req_tready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_tdata,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_taddr,
  output logic                        fifo_axis_tvalid,
  input  logic                        fifo_axis_tready,
  output logic [DATA_W-1:0]           fifo_axis_tdata,
  output logic [ADDR_W-1:0]           fifo_axis_taddr,
  input  logic                        fifo_axis_prog_full,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_active
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_t      state, state_n;
  logic [ID_W-1:0] last, last_n, grant_id_n, pick_id;
  logic [7:0]      cnt, cnt_n, cnt_inc;
  logic            pick_valid, out_ready, accept;

  logic [DATA_W-1:0] lane_data [NUM_REQ];
  logic [ADDR_W-1:0] lane_addr [NUM_REQ];

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .valid     (req_tvalid),
    .last      (last),
    .next      (pick_id),
    .any_valid (pick_valid)
  );

  // Unpack the per-requester payload lanes
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane_data[i] = req_tdata[i*DATA_W +: DATA_W];
      lane_addr[i] = req_taddr[i*ADDR_W +: ADDR_W];
    end
  end

  assign out_ready    = ~fifo_axis_tvalid | fifo_axis_tready;
  assign grant_active = (state == GRANT);

  // Next-state, grant release and requester handshake
  always_comb begin
    state_n    = state;
    grant_id_n = grant_id;
    last_n     = last;
    cnt_n      = cnt;
    req_tready = '0;
    accept     = 1'b0;
    cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    unique case (state)
      IDLE: begin
        if (!fifo_axis_prog_full && pick_valid) begin
          grant_id_n = pick_id;
          cnt_n      = '0;
          state_n    = GRANT;
        end
      end
      GRANT: begin
        req_tready[grant_id] = out_ready & ~fifo_axis_prog_full;
        accept               = req_tvalid[grant_id] & req_tready[grant_id];
        if (accept) begin
          cnt_n = cnt_inc;
        end
        // Release on prog_full, a full burst, or an idle requester that could have sent
        if (fifo_axis_prog_full ||
            (accept && (cnt_inc == 8'(MAX_BURST))) ||
            (!req_tvalid[grant_id] && out_ready)) begin
          state_n = IDLE;
          last_n  = grant_id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sender_clk) begin
    if (!sender_rst_n) begin
      state            <= IDLE;
      last             <= ID_W'(NUM_REQ - 1);
      grant_id         <= '0;
      cnt              <= '0;
      fifo_axis_tvalid <= 1'b0;
      fifo_axis_tdata  <= '0;
      fifo_axis_taddr  <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant_id <= grant_id_n;
      cnt      <= cnt_n;
      // Output stage drains on its own; payload holds while stalled
      if (out_ready) begin
        fifo_axis_tvalid <= accept;
        if (accept) begin
          fifo_axis_tdata <= lane_data[grant_id];
          fifo_axis_taddr <= lane_addr[grant_id];
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Bench for dram_wr_arbiter: cycle table, directed corner sequences and a
// randomized run against a transaction-level scoreboard and round-robin model.
module tb_dram_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 24;
  localparam int MAX_BURST = 8;

  logic                      sender_clk = 1'b0;
  logic                      sender_rst_n;
  logic [NUM_REQ-1:0]        req_tvalid;
  logic [NUM_REQ-1:0]        req_tready;
  logic [NUM_REQ*DATA_W-1:0] req_tdata;
  logic [NUM_REQ*ADDR_W-1:0] req_taddr;
  logic                      fifo_axis_tvalid;
  logic                      fifo_axis_tready;
  logic [DATA_W-1:0]         fifo_axis_tdata;
  logic [ADDR_W-1:0]         fifo_axis_taddr;
  logic                      fifo_axis_prog_full;
  logic [1:0]                grant_id;
  logic                      grant_active;

  always #5 sender_clk = ~sender_clk;

  dram_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .sender_clk          (sender_clk),
    .sender_rst_n        (sender_rst_n),
    .req_tvalid          (req_tvalid),
    .req_tready          (req_tready),
    .req_tdata           (req_tdata),
    .req_taddr           (req_taddr),
    .fifo_axis_tvalid    (fifo_axis_tvalid),
    .fifo_axis_tready    (fifo_axis_tready),
    .fifo_axis_tdata     (fifo_axis_tdata),
    .fifo_axis_taddr     (fifo_axis_taddr),
    .fifo_axis_prog_full (fifo_axis_prog_full),
    .grant_id            (grant_id),
    .grant_active        (grant_active)
  );

  typedef struct {
    logic [3:0]  vld;
    logic        ftr;
    logic        pf;
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] od;
    logic [23:0] oa;
    logic        ga;
    logic [1:0]  gid;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int beat [NUM_REQ];
  logic [DATA_W+ADDR_W-1:0] exp_q [$];
  int          burst_len;
  logic        prev_stall;
  logic [15:0] prev_d;
  logic [23:0] prev_a;
  logic        have_prev, prev_ga, prev_pf;
  logic [3:0]  prev_vld;
  int          model_last;
  logic [3:0]  acc_vec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ldata(input int i, input int k);
    return 16'(32'h00A0 + 16 * i + k);
  endfunction

  function automatic logic [23:0] laddr(input int i, input int k);
    return 24'(32'h000010 + 256 * i + k);
  endfunction

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle
  task automatic drive(input logic [3:0] vld, input logic ftr, input logic pf);
    @(negedge sender_clk);
    sender_rst_n        = 1'b1;
    req_tvalid          = vld;
    fifo_axis_tready    = ftr;
    fifo_axis_prog_full = pf;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tdata[i*DATA_W +: DATA_W] = ldata(i, beat[i]);
      req_taddr[i*ADDR_W +: ADDR_W] = laddr(i, beat[i]);
    end
    #1;
  endtask

  task automatic reset_model();
    exp_q.delete();
    burst_len  = 0;
    prev_stall = 1'b0;
    have_prev  = 1'b0;
    model_last = NUM_REQ - 1;
  endtask

  // Protocol rules, scoreboard and round-robin order checked every sampled cycle
  task automatic observe();
    logic [3:0]  exp_rdy;
    logic        exp_ga;
    int          exp_id;
    logic [39:0] front;
    exp_rdy = '0;
    if (grant_active && !fifo_axis_prog_full && (!fifo_axis_tvalid || fifo_axis_tready))
      exp_rdy[grant_id] = 1'b1;
    check("req_tready_rule", req_tready, exp_rdy);
    if (prev_stall) begin
      check("stall_tvalid", fifo_axis_tvalid, 1);
      check("stall_payload", {fifo_axis_taddr, fifo_axis_tdata}, {prev_a, prev_d});
    end
    if (have_prev && !prev_ga) begin
      exp_ga = !prev_pf && (prev_vld != 4'b0000);
      check("arb_grant_issued", grant_active, exp_ga);
      if (exp_ga) begin
        exp_id = model_last;
        for (int k = NUM_REQ; k >= 1; k--)
          if (prev_vld[(model_last + k) % NUM_REQ]) exp_id = (model_last + k) % NUM_REQ;
        check("rr_grant_id", grant_id, exp_id);
        model_last = exp_id;
      end
    end
    if (fifo_axis_tvalid && fifo_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", fifo_axis_tvalid, 0);
      end else begin
        front = exp_q.pop_front();
        check("fifo_beat", {fifo_axis_taddr, fifo_axis_tdata}, front);
      end
    end
    if (!grant_active) burst_len = 0;
    acc_vec = req_tvalid & req_tready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_vec[i]) begin
        exp_q.push_back({req_taddr[i*ADDR_W +: ADDR_W], req_tdata[i*DATA_W +: DATA_W]});
        beat[i]++;
        burst_len++;
        check("burst_within_max", burst_len <= MAX_BURST, 1);
      end
    end
    prev_stall = fifo_axis_tvalid && !fifo_axis_tready;
    prev_d     = fifo_axis_tdata;
    prev_a     = fifo_axis_taddr;
    prev_ga    = grant_active;
    prev_pf    = fifo_axis_prog_full;
    prev_vld   = req_tvalid;
    have_prev  = 1'b1;
  endtask

  initial begin
    vec_t        tbl [31];
    int          n, b0, tot;
    logic [3:0]  pend, exp_r;
    logic        pf_r, ftr_r;

    tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd0};
    tbl[2]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h00A0, 24'h000010, 1'b1, 2'd0};
    tbl[3]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h00A1, 24'h000011, 1'b1, 2'd0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h00A2, 24'h000012, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd0};
    tbl[6]  = '{4'b1100, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd0};
    tbl[7]  = '{4'b1100, 1'b1, 1'b0, 4'b0100, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd2};
    tbl[8]  = '{4'b1100, 1'b1, 1'b0, 4'b0100, 1'b1, 16'h00C0, 24'h000210, 1'b1, 2'd2};
    tbl[9]  = '{4'b1000, 1'b1, 1'b0, 4'b0100, 1'b1, 16'h00C1, 24'h000211, 1'b1, 2'd2};
    tbl[10] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd2};
    tbl[11] = '{4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd3};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b1000, 1'b1, 16'h00D0, 24'h000310, 1'b1, 2'd3};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd3};
    tbl[14] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd3};
    tbl[15] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd1};
    tbl[16] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 16'h00B0, 24'h000110, 1'b1, 2'd1};
    tbl[17] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 16'h00B1, 24'h000111, 1'b1, 2'd1};
    tbl[18] = '{4'b0111, 1'b1, 1'b1, 4'b0000, 1'b1, 16'h00B2, 24'h000112, 1'b1, 2'd1};
    tbl[19] = '{4'b0111, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd1};
    tbl[20] = '{4'b0111, 1'b1, 1'b1, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd1};
    tbl[21] = '{4'b0111, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd1};
    tbl[22] = '{4'b0111, 1'b1, 1'b0, 4'b0100, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd2};
    tbl[23] = '{4'b0011, 1'b1, 1'b0, 4'b0100, 1'b1, 16'h00C2, 24'h000212, 1'b1, 2'd2};
    tbl[24] = '{4'b0011, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd2};
    tbl[25] = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd0};
    tbl[26] = '{4'b0010, 1'b1, 1'b0, 4'b0001, 1'b1, 16'h00A3, 24'h000013, 1'b1, 2'd0};
    tbl[27] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd0};
    tbl[28] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 16'h0000, 24'h000000, 1'b1, 2'd1};
    tbl[29] = '{4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 16'h00B3, 24'h000113, 1'b1, 2'd1};
    tbl[30] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000, 24'h000000, 1'b0, 2'd1};

    for (int i = 0; i < NUM_REQ; i++) beat[i] = 0;
    sender_rst_n        = 1'b0;
    req_tvalid          = '0;
    req_tdata           = '0;
    req_taddr           = '0;
    fifo_axis_tready    = 1'b1;
    fifo_axis_prog_full = 1'b0;
    reset_model();
    repeat (3) @(negedge sender_clk);

    // Reset values
    drive(4'b0000, 1'b1, 1'b0);
    check("rst_tvalid", fifo_axis_tvalid, 0);
    check("rst_tdata", fifo_axis_tdata, 0);
    check("rst_taddr", fifo_axis_taddr, 0);
    check("rst_req_tready", req_tready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_active", grant_active, 0);
    observe();

    // Single requester burst, drop-valid release, prog_full release
    for (int k = 0; k < 31; k++) begin
      drive(tbl[k].vld, tbl[k].ftr, tbl[k].pf);
      check($sformatf("tbl%0d_req_tready", k), req_tready, tbl[k].rdy);
      check($sformatf("tbl%0d_tvalid", k), fifo_axis_tvalid, tbl[k].ov);
      check($sformatf("tbl%0d_grant_active", k), grant_active, tbl[k].ga);
      check($sformatf("tbl%0d_grant_id", k), grant_id, tbl[k].gid);
      if (tbl[k].ov) begin
        check($sformatf("tbl%0d_tdata", k), fifo_axis_tdata, tbl[k].od);
        check($sformatf("tbl%0d_taddr", k), fifo_axis_taddr, tbl[k].oa);
      end
      observe();
    end

    // FIFO stall mid-burst: payload held, burst count resumes
    b0 = beat[1];
    n  = 0;
    drive(4'b0010, 1'b1, 1'b0); observe();
    drive(4'b0010, 1'b1, 1'b0); observe(); n += $countones(acc_vec);
    drive(4'b0010, 1'b1, 1'b0); observe(); n += $countones(acc_vec);
    for (int s = 0; s < 5; s++) begin
      drive(4'b0010, 1'b0, 1'b0);
      check("stall_req_tready", req_tready, 0);
      check("stall_grant_kept", {grant_active, grant_id}, {1'b1, 2'd1});
      check("stall_held_beat", {fifo_axis_taddr, fifo_axis_tdata}, {laddr(1, b0 + 1), ldata(1, b0 + 1)});
      observe();
    end
    for (int s = 0; s < 20; s++) begin
      drive(4'b0010, 1'b1, 1'b0); observe();
      n += $countones(acc_vec);
      if (!grant_active) break;
    end
    check("stall_burst_total", n, MAX_BURST);
    repeat (2) begin drive(4'b0000, 1'b1, 1'b0); observe(); end

    // Reset mid-burst with an output beat pending
    drive(4'b0100, 1'b1, 1'b0); observe();
    drive(4'b0100, 1'b1, 1'b0); observe();
    drive(4'b0100, 1'b0, 1'b0); observe();
    check("pre_rst_pending", fifo_axis_tvalid, 1);
    @(negedge sender_clk);
    sender_rst_n = 1'b0;
    reset_model();

    // All requesters valid after reset: 0,1,2,3,0, eight beats each, one bubble per burst
    tot = 0;
    for (int c = 0; c < 38; c++) begin
      drive(4'b1111, 1'b1, 1'b0);
      if (c == 0) begin
        check("rst2_outputs", {fifo_axis_tvalid, fifo_axis_tdata, fifo_axis_taddr, req_tready, grant_id, grant_active}, 0);
      end
      exp_r = 4'b0000;
      if (c < 36 && (c % 9) != 0) exp_r = 4'(1 << (c / 9));
      if (c == 37) exp_r = 4'b0001;
      check($sformatf("allvld_c%0d_req_tready", c), req_tready, exp_r);
      if (c == 37) check("allvld_wrap_grant", {grant_active, grant_id}, {1'b1, 2'd0});
      observe();
      if (c < 36) tot += $countones(acc_vec);
    end
    check("allvld_beats_in_36", tot, 32);

    // Randomized traffic with back-pressure and prog_full
    pend = 4'b1111;
    pf_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i]) pend[i] = ($urandom_range(0, 9) < 6);
      ftr_r = ($urandom_range(0, 9) < 7);
      pf_r  = pf_r ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 5);
      drive(pend, ftr_r, pf_r);
      observe();
      pend &= ~acc_vec;
    end
    for (int c = 0; c < 400; c++) begin
      if (pend == 4'b0000 && exp_q.size() == 0 && !fifo_axis_tvalid) break;
      drive(pend, 1'b1, 1'b0);
      observe();
      pend &= ~acc_vec;
    end
    check("drain_pending", pend, 0);
    check("drain_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
